// File: rtl/ram_param.sv
// Parametrised single-port RAM with byte enables, post-reset INIT_VAL fill and out-of-range flagging.
// Latency: reads return data_out/rvalid one cycle after acceptance; writes commit at the accepting edge.
// Backpressure: ready is low only during the DEPTH-cycle init sweep; requests while not ready are dropped.
module ram_param #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 5,
    parameter int                 DEPTH    = 32,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0,
    localparam int                BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wena,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              err,
    output logic              init_done
);

    // Two-state controller: sweeping memory with INIT_VAL, then serving requests.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    // The sweep pointer is one bit wider than the address so that a full
    // power-of-two depth can reach its last word without wrapping to zero.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   ptr_q,   ptr_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q,    err_d;
    logic [DATA_W-1:0] dout_q,   dout_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Memory write port, shared between the init sweep and user writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;

    logic              in_range;

    // A full power-of-two depth has no unmapped addresses, so the range check
    // collapses to a constant instead of a comparison that can never fail.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
            assign in_range = 1'b1;
        end else begin : g_partial_depth
            assign in_range = ({1'b0, addr} < DEPTH_W);
        end
    endgenerate

    // Next-state logic: sweep control in INIT, request decode in IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_be    = be;
        mem_wdata = data_in;

        case (state_q)
            ST_INIT: begin
                // Every init cycle fills one whole word; the last word hands over to IDLE.
                mem_we    = 1'b1;
                mem_addr  = ptr_q[ADDR_W-1:0];
                mem_be    = '1;
                mem_wdata = INIT_VAL;
                ptr_d     = ptr_q + PTR_ONE;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // ready is constantly high here, so req alone means acceptance.
                if (req) begin
                    err_d = ~in_range;
                    if (wena) begin
                        // Out-of-range writes are swallowed; be=0 is a harmless no-op.
                        mem_we = in_range;
                    end else begin
                        rvalid_d = 1'b1;
                        dout_d   = in_range ? mem_q[addr] : '0;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Control and output registers; reset restarts the sweep and drops any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array with per-byte-lane writes; contents are only ever set by the sweep or user writes.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (mem_be[k]) begin
                    mem_q[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign init_done = (state_q == ST_IDLE);
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: a default 32x8 instance and a 20x32 instance (non power-of-two depth,
// non-zero INIT_VAL) share one stimulus stream; a word-array model predicts each response and
// a negedge monitor pops and compares the expected responses against each instance.
module tb_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int          DEPTH_A = 32;
    localparam int          DEPTH_B = 20;
    localparam logic [31:0] INIT_A  = 32'h0;
    localparam logic [31:0] INIT_B  = 32'hA5A5_A5A5;

    logic        rst, req, wena;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;

    logic        ready_a, rvalid_a, err_a, idone_a;
    logic [7:0]  dout_a;
    logic        ready_b, rvalid_b, err_b, idone_b;
    logic [31:0] dout_b;

    ram_param u_a (
        .clk(clk), .rst(rst), .req(req), .wena(wena), .addr(addr),
        .be(be[0:0]), .data_in(din[7:0]),
        .ready(ready_a), .data_out(dout_a), .rvalid(rvalid_a), .err(err_a), .init_done(idone_a)
    );

    ram_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH_B), .INIT_VAL(INIT_B)) u_b (
        .clk(clk), .rst(rst), .req(req), .wena(wena), .addr(addr),
        .be(be), .data_in(din),
        .ready(ready_b), .data_out(dout_b), .rvalid(rvalid_b), .err(err_b), .init_done(idone_b)
    );

    typedef struct {
        int          due;
        logic        rv;
        logic        er;
        logic [31:0] dat;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_a [DEPTH_A];
    logic [31:0] mem_b [DEPTH_B];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int          cyc    = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Byte-lane merge: the word as it should read after a masked write.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b, input int lanes);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < lanes; k++) begin
            if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Monitor: every cycle either the expected response is due, or no pulse and data_out holds.
    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            chk("a_rvalid", 32'(rvalid_a), 32'(e.rv));
            chk("a_err",    32'(err_a),    32'(e.er));
            if (e.rv) last_a = e.dat;
        end else begin
            chk("a_no_pulse", 32'({rvalid_a, err_a}), 32'd0);
        end
        chk("a_data_out", 32'(dout_a), last_a);

        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            chk("b_rvalid", 32'(rvalid_b), 32'(e.rv));
            chk("b_err",    32'(err_b),    32'(e.er));
            if (e.rv) last_b = e.dat;
        end else begin
            chk("b_no_pulse", 32'({rvalid_b, err_b}), 32'd0);
        end
        chk("b_data_out", dout_b, last_b);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0;
        step();
    endtask

    // One accepted access per call; the model decides what each instance must answer next cycle.
    task automatic access(input logic w, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        chk("ready_before_req", 32'({ready_a, ready_b}), 32'd3);
        req  = 1'b1;
        wena = w;
        addr = a;
        be   = b;
        din  = d;

        if (w) begin
            mem_a[a] = merge(mem_a[a], d, b, 1);
        end else begin
            e.due = cyc + 1; e.rv = 1'b1; e.er = 1'b0; e.dat = mem_a[a];
            qa.push_back(e);
        end

        if (a < DEPTH_B) begin
            if (w) begin
                mem_b[a] = merge(mem_b[a], d, b, 4);
            end else begin
                e.due = cyc + 1; e.rv = 1'b1; e.er = 1'b0; e.dat = mem_b[a];
                qb.push_back(e);
            end
        end else begin
            e.due = cyc + 1; e.rv = ~w; e.er = 1'b1; e.dat = '0;
            qb.push_back(e);
        end
        step();
    endtask

    // Reset, optionally with a read request on the reset edge and/or a second rst
    // pulse after 'glitch' init cycles; then measure the sweep length of both instances.
    task automatic do_reset(input int hold, input int glitch, input logic with_req);
        int first_a, first_b;
        rst    = 1'b1;
        req    = with_req;
        wena   = 1'b0;
        addr   = 5'd7;
        last_a = '0;
        last_b = '0;
        step();
        req = 1'b0;
        chk("rst_ready",     32'({ready_a, ready_b}), 32'd0);
        chk("rst_init_done", 32'({idone_a, idone_b}), 32'd0);
        repeat (hold - 1) step();
        rst = 1'b0;
        if (glitch >= 0) begin
            repeat (glitch) step();
            chk("mid_init_ready", 32'({ready_a, ready_b}), 32'd0);
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        first_a = -1;
        first_b = -1;
        for (int i = 1; i <= 64 && (first_a < 0 || first_b < 0); i++) begin
            step();
            if (first_a < 0 && ready_a) first_a = i;
            if (first_b < 0 && ready_b) first_b = i;
            chk("init_done_a", 32'(idone_a), 32'(first_a >= 0));
            chk("init_done_b", 32'(idone_b), 32'(first_b >= 0));
        end
        chk("init_len_a", first_a, DEPTH_A);
        chk("init_len_b", first_b, DEPTH_B);
        for (int k = 0; k < DEPTH_A; k++) mem_a[k] = INIT_A;
        for (int k = 0; k < DEPTH_B; k++) mem_b[k] = INIT_B;
    endtask

    task automatic random_ops(input int n);
        repeat (n) begin
            if ($urandom_range(3) == 0) idle();
            else access(1'($urandom_range(1)), 5'($urandom_range(31)), 4'($urandom_range(15)), $urandom);
        end
        idle();
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        wena = 1'b0;
        addr = '0;
        be   = '0;
        din  = '0;

        do_reset(2, -1, 1'b0);

        // Freshly initialised word.
        access(1'b0, 5'b10010, 4'h0, 32'h0);
        idle();

        // Two writes, then back-to-back reads.
        access(1'b1, 5'b10010, 4'hF, 32'h0000_009F);
        access(1'b1, 5'b00010, 4'hF, 32'h0000_00FF);
        access(1'b0, 5'b10010, 4'h0, 32'h0);
        access(1'b0, 5'b00010, 4'h0, 32'h0);
        idle();

        // Byte-lane merge: the wide instance must read AA22CC44.
        access(1'b1, 5'd3, 4'hF,    32'hAABB_CCDD);
        access(1'b1, 5'd3, 4'b0101, 32'h1122_3344);
        access(1'b0, 5'd3, 4'h0,    32'h0);
        idle();

        // Out-of-range on the 20-deep instance, and no aliasing onto addr 5.
        access(1'b1, 5'd25, 4'hF, 32'h0000_005A);
        access(1'b0, 5'd25, 4'h0, 32'h0);
        access(1'b0, 5'd5,  4'h0, 32'h0);
        access(1'b0, 5'd31, 4'h0, 32'h0);
        idle();

        // Zero byte-enable write, then read-after-write on the next cycle.
        access(1'b1, 5'd9, 4'h0, 32'hDEAD_BEEF);
        access(1'b1, 5'd7, 4'hF, 32'h1234_5678);
        access(1'b0, 5'd7, 4'h0, 32'h0);
        access(1'b0, 5'd9, 4'h0, 32'h0);
        idle();

        random_ops(600);

        // rst pulse in the middle of the sweep restarts it.
        do_reset(1, 4, 1'b0);
        for (int k = 0; k < 32; k++) access(1'b0, 5'(k), 4'h0, 32'h0);
        idle();
        random_ops(150);

        // rst together with a read request in IDLE: request dropped, memory re-swept.
        do_reset(1, -1, 1'b1);
        for (int k = 0; k < 32; k++) access(1'b0, 5'(k), 4'h0, 32'h0);
        idle();
        random_ops(100);

        repeat (3) idle();
        chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 32x8 RAM.
- Adds configurable width and depth, per-byte write enables, and a request/ready handshake with a registered read-valid pulse.
- Adds a post-reset initialisation sweep that fills every word with INIT_VAL.
- An out-of-range address flag covers depths that are not a power of two.
- Used as the generic scratch/buffer memory behind datapath blocks.

Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 5: address port width.
- DEPTH, 32: number of words; 1 <= DEPTH <= 2**ADDR_W.
- INIT_VAL, 0: DATA_W-bit value written to every word during the init sweep.
- BE_W (localparam): DATA_W/8, the number of byte lanes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; accepted when req & ready.
- wena  in  1  1 = write, 0 = read; sampled on acceptance.
- addr  in  ADDR_W  word address.
- be  in  BE_W  byte enables for writes; ignored on reads.
- data_in  in  DATA_W  write data.
- ready  out  1  block can accept a request this cycle.
- data_out  out  DATA_W  read data; holds the last read value.
- rvalid  out  1  one-cycle pulse: data_out is updated with a read result.
- err  out  1  one-cycle pulse: the accepted request had addr >= DEPTH.
- init_done  out  1  high once the init sweep has completed.

Behaviour:
- Reset (rst=1 at an edge): state<=INIT, sweep pointer<=0. Outputs: ready=0, rvalid=0, err=0, init_done=0, data_out=0. Memory contents are not reset directly; the sweep overwrites them.
- FSM with 2 states, INIT and IDLE:
  - INIT: each cycle writes INIT_VAL to mem[ptr], all bytes, then ptr++. On the edge that writes ptr=DEPTH-1, go to IDLE.
  - INIT takes exactly DEPTH cycles after rst deasserts. ready and init_done both rise in the cycle after the last init write, and init_done stays high until the next rst.
  - IDLE: ready=1 every cycle. No back-pressure and no multi-cycle ops.
- req while ready=0 is ignored, not queued. The requester must hold req until it sees ready.
- Write (req & ready & wena, addr < DEPTH):
  - At the edge, mem[addr] byte lane k <= data_in[8k+7:8k] for each be[k]=1; other lanes are unchanged.
  - be=0 gives a legal no-op write.
  - No rvalid; data_out unchanged.
- Read (req & ready & !wena, addr < DEPTH):
  - At the edge, data_out <= mem[addr] and rvalid=1 for the following cycle only. Latency is 1 cycle.
  - Back-to-back reads give one rvalid per accepted read, in order.
- Read of a word written in the previous cycle returns the new data (the write has already committed at the earlier edge).
- Out of range (addr >= DEPTH, accepted):
  - Write: memory unchanged.
  - Read: data_out <= 0 and rvalid pulses.
  - Either case: err pulses 1 cycle, aligned with where rvalid would be.
  - When DEPTH = 2**ADDR_W, err never asserts.
- Reset mid-operation: rst during INIT restarts the sweep from ptr=0. rst in IDLE drops ready the next cycle and re-runs the sweep. rst beats a simultaneous req: the request is dropped and rvalid/err stay 0.
- Sweep pointer width: ADDR_W+1 bits, so DEPTH = 2**ADDR_W terminates without wrap.

Test Plan:
1. Defaults; rst high 2 cycles, then low -> ready=0 for exactly 32 cycles, then ready=1 and init_done=1. A read of addr 5'b10010 returns 8'h00 with rvalid one cycle after acceptance.
2. Defaults: write addr 5'b10010 = 8'h9F, write addr 5'b00010 = 8'hFF, read 5'b10010, read 5'b00010 back-to-back -> data_out 8'h9F then 8'hFF on consecutive cycles, each with rvalid=1 and err=0.
3. DATA_W=32: write addr 3 = 32'hAABBCCDD with be=4'hF, then write 32'h11223344 with be=4'b0101, then read addr 3 -> 32'hAA22CC44.
4. DEPTH=20, ADDR_W=5: write 8'h5A to addr 25, then read addr 25 -> err pulses on both accesses; the read gives data_out=8'h00 with rvalid=1; addr 25 mod 20 is not corrupted (read addr 5 = INIT_VAL).
5. INIT_VAL=8'hA5, DEPTH=8: assert rst at init cycle 4 for 1 cycle -> the sweep restarts, ready rises exactly 8 cycles after rst deasserts, and reads of addrs 0..7 all return 8'hA5.
6. In IDLE, assert rst together with a read req -> rvalid stays 0 and ready=0 the next cycle. Previously written data at untouched addresses is overwritten with INIT_VAL after the sweep.
